// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition recorder.
package acq_pkg;

    // STP: stopped, PRE: filling pre-trigger history, ARM: waiting for trigger, PST: post-trigger capture
    typedef enum logic [1:0] {
        STP = 2'd0,
        PRE = 2'd1,
        ARM = 2'd2,
        PST = 2'd3
    } acq_state_t;

endpackage

// File: rtl/evn_pkg.sv
// Event bundle shared by acquisition blocks: reset, start, stop and software trigger.
package evn_pkg;

    typedef struct packed {
        logic rst;
        logic str;
        logic stp;
        logic swt;
    } evn_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; AN lanes of sample type DT packed into TDATA.
interface axi4_stream_if #(
    parameter int  AN = 1,
    parameter type DT = logic signed [14-1:0]
) ();

    localparam int DW = AN * $bits(DT);

    logic          TVALID;
    logic          TREADY;
    logic [DW-1:0] TDATA;
    logic [AN-1:0] TKEEP;
    logic          TLAST;

    // Handshake: a beat transfers on every ACLK edge with TVALID & TREADY high; the source keeps TVALID, TDATA, TKEEP and TLAST stable until that edge.
    modport s (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);
    modport d (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);

endinterface

// File: rtl/axi4_stream_reg.sv
// One-deep stream register slice: full throughput, one cycle latency, holds under back-pressure.
module axi4_stream_reg #(
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;

    assign o_ready = i_ready | ~r_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    // Capture an accepted beat; otherwise empty the slice once the consumer has taken it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/acq_rec.sv
// Triggered acquisition recorder: forwards samples while started, counts pre/post-trigger
// beats and closes the record with TLAST after the configured post-trigger length.
module acq_rec
    import acq_pkg::*;
#(
    parameter int  AN = 1,
    parameter type DT = logic signed [14-1:0],
    parameter int  CW = 32
) (
    input  logic          ACLK,
    input  logic          ARESET,
    axi4_stream_if.d      sti,
    axi4_stream_if.s      sto,
    input  evn_pkg::evn_t evn,
    output evn_pkg::evn_t evs,
    input  logic          ctl_trg,
    input  logic          cfg_con,
    input  logic [CW-1:0] cfg_pre,
    input  logic [CW-1:0] cfg_pst,
    output logic [CW-1:0] sts_pre,
    output logic [CW-1:0] sts_pst
);

    localparam int            DW  = AN * $bits(DT);
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    acq_state_t    r_state;
    logic [CW-1:0] r_pre;
    logic [CW-1:0] r_pst;

    logic          w_clr;
    logic          w_beat;
    logic          w_fwd;
    logic          w_trg;
    logic          w_acc;
    logic          w_pst_inc;
    logic [CW-1:0] w_pst_nxt;
    logic          w_last;
    logic          w_end;
    logic [CW:0]   w_pre_inc;
    logic          w_pre_done;
    logic          w_slv_ready;
    logic          w_unused;

    // The event reset behaves exactly like ARESET, output slice included.
    assign w_clr = ARESET | evn.rst;

    // While stopped the input is drained and discarded, so it never stalls upstream.
    assign sti.TREADY = (r_state == STP) | w_slv_ready;
    assign w_beat     = sti.TVALID & sti.TREADY;
    assign w_fwd      = sti.TVALID & (r_state != STP);

    // A trigger is taken in ARM, or together with a start when no pre-trigger history is needed.
    assign w_trg = evn.swt | ctl_trg;
    assign w_acc = w_trg & ~evn.stp &
                   (((r_state == ARM) & ~evn.str) |
                    ((r_state == STP) & evn.str & (cfg_pre == '0)));

    // The beat in the trigger cycle is the first post-trigger beat.
    assign w_pst_inc = w_beat & ((r_state == PST) | ((r_state == ARM) & w_acc));
    assign w_pst_nxt = (w_acc ? '0 : r_pst) + (w_pst_inc ? ONE : '0);
    assign w_end     = ~cfg_con & ((w_pst_inc & (w_pst_nxt == cfg_pst)) |
                                   (w_acc & (cfg_pst == '0)));
    assign w_last    = evn.stp | (~cfg_con & w_pst_inc & (w_pst_nxt == cfg_pst));

    // Extra bit keeps the comparison exact even when the counter sits at its ceiling.
    assign w_pre_inc  = {1'b0, r_pre} + {1'b0, ONE};
    assign w_pre_done = w_beat & (w_pre_inc >= {1'b0, cfg_pre});

    // Recorder state and its pre/post-trigger beat counters.
    always_ff @(posedge ACLK) begin
        if (w_clr) begin
            r_state <= STP;
            r_pre   <= '0;
            r_pst   <= '0;
        end else begin
            if (evn.str && !evn.stp) begin
                r_pre <= '0;
            end else if (w_beat && ((r_state == PRE) || (r_state == ARM)) && (r_pre != '1)) begin
                r_pre <= r_pre + ONE;
            end

            if (w_acc || w_pst_inc) begin
                r_pst <= w_pst_nxt;
            end

            if (evn.stp) begin
                r_state <= STP;
            end else begin
                case (r_state)
                    STP: begin
                        if (evn.str) begin
                            if (cfg_pre != '0) begin
                                r_state <= PRE;
                            end else if (w_acc) begin
                                r_state <= w_end ? STP : PST;
                            end else begin
                                r_state <= ARM;
                            end
                        end
                    end
                    PRE: begin
                        if (w_pre_done) begin
                            r_state <= ARM;
                        end
                    end
                    ARM: begin
                        if (w_acc) begin
                            r_state <= w_end ? STP : PST;
                        end
                    end
                    PST: begin
                        if (w_end) begin
                            r_state <= STP;
                        end
                    end
                    default: r_state <= STP;
                endcase
            end
        end
    end

    axi4_stream_reg #(
        .DW (DW)
    ) u_reg (
        .clk     (ACLK),
        .rst     (w_clr),
        .i_valid (w_fwd),
        .o_ready (w_slv_ready),
        .i_data  (sti.TDATA),
        .i_last  (w_last),
        .o_valid (sto.TVALID),
        .i_ready (sto.TREADY),
        .o_data  (sto.TDATA),
        .o_last  (sto.TLAST)
    );

    assign sto.TKEEP = '1;

    assign evs.rst = 1'b0;
    assign evs.str = (r_state != STP);
    assign evs.stp = (r_state == STP);
    assign evs.swt = (r_state == PST);

    assign sts_pre = r_pre;
    assign sts_pst = r_pst;

    // Input keep/last carry no meaning for a sample stream.
    assign w_unused = &{1'b0, sti.TKEEP, sti.TLAST};

endmodule

// File: doc/acq_rec.md
ACQ_REC -- requirements
Module: acq_rec

Interface
REQ-001 Parameter: AN, 1, number of data lanes per stream beat.
REQ-002 Parameter: DT, logic signed [14-1:0], sample data type.
REQ-003 Parameter: CW, 32, width of the pre-trigger and post-trigger counters.
REQ-004 Port: ACLK  in  1  clock; all logic, including both streams, is clocked on ACLK.
REQ-005 Port: ARESET  in  1  reset, synchronous, active-high.
REQ-006 Port: sti  axi4_stream_if.d  AN x DT  sample stream input (destination).
REQ-007 Port: sto  axi4_stream_if.s  AN x DT  acquired stream output (source).
REQ-008 Port: evn  in  evn_pkg::evn_t  input events rst/str/stp/swt.
REQ-009 Port: evs  out  evn_pkg::evn_t  status events.
REQ-010 Port: ctl_trg  in  1  hardware trigger pulse.
REQ-011 Port: cfg_con  in  1  continuous mode (post-trigger count ignored).
REQ-012 Port: cfg_pre  in  CW  required pre-trigger beats before a trigger is accepted.
REQ-013 Port: cfg_pst  in  CW  post-trigger beats, trigger beat included.
REQ-014 Port: sts_pre  out  CW  pre-trigger beat count, saturating.
REQ-015 Port: sts_pst  out  CW  post-trigger beat count.

Function
REQ-016 A beat (handshake) SHALL be sti.TVALID & sti.TREADY; counters SHALL advance only on beats.
REQ-017 The output SHALL be one register slice: latency 1 cycle; sti.TREADY = sto.TREADY | ~sto.TVALID.
REQ-018 While stopped, sti.TREADY SHALL be 1, and input beats SHALL be discarded (sto.TVALID stays 0).
REQ-019 FSM states: STP (stopped), PRE (started, sts_pre < cfg_pre), ARM (pre satisfied, awaiting trigger), PST (triggered).
REQ-020 STP->PRE on evn.str; STP->ARM directly when cfg_pre = 0.
REQ-021 PRE->ARM on the beat where sts_pre+1 reaches cfg_pre.
REQ-022 Trigger = evn.swt | ctl_trg; it SHALL be accepted only in ARM, or in STP together with evn.str when cfg_pre = 0, and SHALL move the FSM to PST.
REQ-023 Triggers in STP (without the cfg_pre = 0 start case), PRE, and PST SHALL be ignored.
REQ-024 sts_pre SHALL clear on evn.str, increment on beats in PRE/ARM, and saturate at 2**CW-1.
REQ-025 sts_pst SHALL clear on acceptance and increment on beats in PST, the trigger-cycle beat included.
REQ-026 With cfg_con = 0, the beat that makes sts_pst equal to cfg_pst SHALL carry TLAST = 1, and the FSM SHALL return to STP.
REQ-027 With cfg_con = 0 and cfg_pst = 0, the FSM SHALL end immediately on acceptance with no TLAST beat.
REQ-028 evn.stp SHALL force STP; a beat in that cycle SHALL be forwarded with TLAST = 1.
REQ-029 Priority: evn.rst > evn.stp > evn.str > trigger.
REQ-030 evn.rst SHALL clear the FSM, counters, and output register synchronously, identically to ARESET.
REQ-031 evs.str = FSM != STP; evs.stp = ~evs.str; evs.swt = (FSM == PST); evs.rst = 0.
REQ-032 sto.TKEEP SHALL be all ones.
REQ-033 Back-pressure SHALL NOT lose or duplicate data: the output slice holds while sto.TREADY = 0.

Reset
REQ-034 On ARESET: the FSM SHALL be in STP, and sts_pre, sts_pst, sto.TVALID, and sto.TLAST SHALL be 0.
REQ-035 On ARESET, sto.TDATA SHALL be 0.
REQ-036 On ARESET, evs.str and evs.swt SHALL be 0, and evs.stp SHALL be 1.
REQ-037 Reset mid-acquisition SHALL drop any held beat without asserting TLAST.

Structure
REQ-038 The FSM state enum SHALL live in a shared package acq_pkg; evn_t SHALL stay in evn_pkg.
REQ-039 The output register slice SHALL be sub-module axi4_stream_reg, reusable.

Verification
REQ-040 cfg_pre=4, cfg_pst=8, cfg_con=0: str, 10 beats, then ctl_trg -> 8 beats out after the trigger, TLAST on the 8th, then evs.str=0.
REQ-041 cfg_pre=4: ctl_trg after the 2nd beat -> ignored; sts_pre=4; evs.swt stays 0 until the next trigger.
REQ-042 cfg_pre=0: evn.str and evn.swt in the same cycle -> evs.swt=1 the next cycle; sts_pst counts from 0.
REQ-043 cfg_con=1, cfg_pst=3: trigger then 20 beats -> no TLAST, sts_pst=20; evn.stp with a beat -> TLAST on that beat.
REQ-044 Random sto.TREADY at 50%: output sequence equals the input sequence, with no loss or duplicates.
REQ-045 ARESET asserted in PST -> all outputs at reset values the next cycle; no TLAST emitted.
